// File: rtl/stim_gen.sv
// Pattern generator: up/down/triangle sequences (plus Galois LFSR in mode 3 when
// STIM_GEN_LFSR_EN is defined) on a registered valid/ready stream; config latched at start.
module stim_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS = 8'hB8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] limit,
  input  logic [DATA_WIDTH-1:0] step,
  output logic                  ovalid,
  input  logic                  oready,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  olast,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  logic                  dir;
  logic [1:0]            cfg_mode;
  logic [DATA_WIDTH-1:0] cfg_limit;
  logic [DATA_WIDTH-1:0] cfg_step;

  logic [1:0]            in_mode;
  logic [DATA_WIDTH-1:0] in_step;
  logic [1:0]            m;
  logic [DATA_WIDTH-1:0] lim;
  logic [DATA_WIDTH-1:0] stp;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   nsum;
  logic [DATA_WIDTH-1:0] nv;
  logic                  ndir;
  logic                  nl;

`ifdef STIM_GEN_LFSR_EN
  logic [DATA_WIDTH-1:0] seed;

  function automatic logic [DATA_WIDTH-1:0] lfsr_next(input logic [DATA_WIDTH-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

  assign in_mode = mode;
  assign seed    = (lim == '0) ? DATA_WIDTH'(1) : lim;
`else
  logic unused_taps;
  assign unused_taps = ^LFSR_TAPS;
  assign in_mode     = (mode == 2'd3) ? 2'd0 : mode;
`endif

  assign in_step = (step == '0) ? DATA_WIDTH'(1) : step;

  // In IDLE the first value is derived from the live inputs being latched this cycle.
  assign m   = (state == IDLE) ? in_mode : cfg_mode;
  assign lim = (state == IDLE) ? limit   : cfg_limit;
  assign stp = (state == IDLE) ? in_step : cfg_step;
  assign sum = {1'b0, odata} + {1'b0, stp};

  always_comb begin
    nv   = '0;
    ndir = 1'b0;
    if (state == IDLE) begin
      case (m)
        2'd1:    nv = lim;
`ifdef STIM_GEN_LFSR_EN
        2'd3:    nv = seed;
`endif
        default: nv = '0;
      endcase
    end else begin
      case (m)
        2'd1: nv = (odata >= stp) ? odata - stp : lim;
        2'd2: begin
          if (!dir) begin
            nv   = (sum > {1'b0, lim}) ? lim : sum[DATA_WIDTH-1:0];
            ndir = (nv == lim);
          end else begin
            nv   = (odata >= stp) ? odata - stp : '0;
            ndir = (nv != '0);
          end
        end
`ifdef STIM_GEN_LFSR_EN
        2'd3: nv = lfsr_next(odata);
`endif
        default: nv = (sum <= {1'b0, lim}) ? sum[DATA_WIDTH-1:0] : '0;
      endcase
    end
  end

  // End-of-period flag travels with the value it describes.
  assign nsum = {1'b0, nv} + {1'b0, stp};

  always_comb begin
    nl = 1'b0;
    case (m)
      2'd1:    nl = (nv < stp);
      2'd2:    nl = (state == RUN) && (nv == '0);
`ifdef STIM_GEN_LFSR_EN
      2'd3:    nl = (lfsr_next(nv) == seed);
`endif
      default: nl = (nsum > {1'b0, lim});
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      dir       <= 1'b0;
      ovalid    <= 1'b0;
      odata     <= '0;
      olast     <= 1'b0;
      beat_cnt  <= '0;
      cfg_mode  <= 2'd0;
      cfg_limit <= '0;
      cfg_step  <= DATA_WIDTH'(1);
    end else begin
      case (state)
        IDLE: begin
          ovalid <= 1'b0;
          if (enable) begin
            cfg_mode  <= in_mode;
            cfg_limit <= limit;
            cfg_step  <= in_step;
            odata     <= nv;
            olast     <= nl;
            dir       <= ndir;
            ovalid    <= 1'b1;
            beat_cnt  <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (ovalid && oready) begin
            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            if (enable) begin
              odata <= nv;
              olast <= nl;
              dir   <= ndir;
            end else begin
              ovalid <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
